tri_unpacker: RTL

TRI_UNPACKER -- requirements
Module: tri_unpacker

---
 rtl/tri_unpacker.sv | 106 ++++++++++
 1 files changed

// File: rtl/tri_unpacker.sv
// Triangle unpacker: dequeues one 256-bit triangle record and streams its
// three vertices to rasterizer setup over a valid/ready handshake.
module tri_unpacker #(
  parameter bit CULL_DEGENERATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         q_empty,
  input  logic [255:0] q_data,
  output logic         deq,
  output logic         vtx_valid,
  input  logic         vtx_ready,
  output logic [15:0]  vtx_x,
  output logic [15:0]  vtx_y,
  output logic [15:0]  vtx_z,
  output logic [31:0]  vtx_color,
  output logic [1:0]   vtx_idx,
  output logic         vtx_last,
  output logic [15:0]  tri_id,
  output logic [15:0]  tri_cnt,
  output logic [15:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, EMIT} state_t;

  state_t        state;
  logic          armed;
  logic [255:0]  hold;
  logic [79:0]   vsel;
  logic          degenerate;

  // xy of vertex k lives in the low 32 bits of its 80-bit slot
  assign degenerate = CULL_DEGENERATE &&
                      ((q_data[31:0]   == q_data[111:80])  ||
                       (q_data[111:80] == q_data[191:160]) ||
                       (q_data[31:0]   == q_data[191:160]));

  always_comb begin
    vsel = hold[79:0];
    case (vtx_idx)
      2'd0:    vsel = hold[79:0];
      2'd1:    vsel = hold[159:80];
      default: vsel = hold[239:160];
    endcase
  end

  assign vtx_x     = vsel[15:0];
  assign vtx_y     = vsel[31:16];
  assign vtx_z     = vsel[47:32];
  assign vtx_color = vsel[79:48];
  assign vtx_last  = (vtx_idx == 2'd2);
  assign tri_id    = hold[255:240];

  // armed holds off the first request for one cycle after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      deq       <= 1'b0;
      vtx_valid <= 1'b0;
      vtx_idx   <= 2'd0;
      hold      <= '0;
      tri_cnt   <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && !q_empty) begin
            state <= REQ;
            deq   <= 1'b1;
          end
        end
        REQ: begin
          deq   <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          if (degenerate) begin
            drop_cnt <= drop_cnt + 16'd1;
            state    <= IDLE;
          end else begin
            hold      <= q_data;
            vtx_idx   <= 2'd0;
            vtx_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (vtx_ready) begin
            if (vtx_idx == 2'd2) begin
              vtx_valid <= 1'b0;
              vtx_idx   <= 2'd0;
              tri_cnt   <= tri_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              vtx_idx <= vtx_idx + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
